// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch stage.
// Generates the PC and fetches from instruction memory over a req/ack handshake.
// It presents PC+4, the instruction and a flush flag to the IF/ID register.
// A one-entry buffer keeps an instruction that arrives while IF/ID is stalled.
//
// Ports:
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_stall      1 = IF/ID holds (shared with the IF/ID write-hold input)
//   i_redirect   taken branch/jump, load i_target
//   i_target     redirect address, bits [1:0] ignored
//   o_imem_req   fetch request
//   o_imem_addr  word-aligned fetch address
//   i_imem_ack   request complete / data valid
//   i_imem_data  instruction, valid with i_imem_ack
//   o_pc4        PC+4 of the presented instruction
//   o_order      presented instruction, 0 while o_flash=1
//   o_flash      bubble/flush into IF/ID
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_target,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ack,
  input  logic [31:0] i_imem_data,
  output logic [31:0] o_pc4,
  output logic [31:0] o_order,
  output logic        o_flash
);

  typedef enum logic [1:0] {StIdle, StWait, StHold, StDrain} state_e;

  localparam logic [31:0] ResetPcAligned = {RESET_PC[31:2], 2'b00};

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_buf;
  // Address of the request being drained; the PC may already point at a redirect
  // target, but the memory needs the old address held until it acks.
  logic [31:0] r_drain_addr;

  logic [31:0] w_pc4;
  logic [31:0] w_target;

  assign w_pc4    = r_pc + 32'd4;
  assign w_target = {i_target[31:2], 2'b00};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_pc         <= ResetPcAligned;
      r_buf        <= 32'd0;
      r_drain_addr <= ResetPcAligned;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_redirect) r_pc <= w_target;
          r_state <= StWait;
        end
        StWait: begin
          if (i_redirect) begin
            r_pc <= w_target;
            if (i_imem_ack) begin
              r_state <= StWait;
            end else begin
              r_drain_addr <= r_pc;
              r_state      <= StDrain;
            end
          end else if (i_imem_ack && !i_stall) begin
            r_pc <= w_pc4;
          end else if (i_imem_ack && i_stall) begin
            r_buf   <= i_imem_data;
            r_state <= StHold;
          end
        end
        StHold: begin
          if (i_redirect) begin
            r_pc    <= w_target;
            r_buf   <= 32'd0;
            r_state <= StWait;
          end else if (!i_stall) begin
            r_pc    <= w_pc4;
            r_state <= StWait;
          end
        end
        StDrain: begin
          if (i_redirect) r_pc <= w_target;
          // The outstanding request's data is always discarded.
          if (i_imem_ack) r_state <= StWait;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_imem_req  = 1'b0;
    o_imem_addr = r_pc;
    o_order     = 32'd0;
    o_pc4       = w_pc4;
    o_flash     = 1'b1;
    unique case (r_state)
      StIdle: ;
      StWait: begin
        o_imem_req = 1'b1;
        if (i_imem_ack && !i_stall) begin
          o_order = i_imem_data;
          o_flash = 1'b0;
        end else if (i_imem_ack) begin
          o_flash = 1'b0;
        end else begin
          // Flush would override the IF/ID hold, so never raise it while stalled.
          o_flash = !i_stall;
        end
      end
      StHold: begin
        o_order = r_buf;
        o_flash = 1'b0;
      end
      StDrain: begin
        o_imem_req  = 1'b1;
        o_imem_addr = r_drain_addr;
      end
      default: ;
    endcase
    if (i_redirect) begin
      o_flash = 1'b1;
      o_order = 32'd0;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] target;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] data;
  logic [31:0] pc4;
  logic [31:0] order;
  logic        flash;

  // Memory model: auto = zero-wait (ACK=REQ, DATA=ADDR|0x10000000), else manual.
  logic        auto;
  logic        ack_man;
  logic [31:0] data_man;

  assign ack  = auto ? req : ack_man;
  assign data = auto ? (addr | 32'h1000_0000) : data_man;

  // Second instance for PC wrap-around, always zero-wait memory.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_pc4;
  logic [31:0] w_order;
  logic        w_flash;
  logic        w_stall;
  logic        w_redirect;
  logic [31:0] w_target;

  int checks;
  int failures;

  ifetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_stall    (stall),
    .i_redirect (redirect),
    .i_target   (target),
    .o_imem_req (req),
    .o_imem_addr(addr),
    .i_imem_ack (ack),
    .i_imem_data(data),
    .o_pc4      (pc4),
    .o_order    (order),
    .o_flash    (flash)
  );

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_stall    (w_stall),
    .i_redirect (w_redirect),
    .i_target   (w_target),
    .o_imem_req (w_req),
    .o_imem_addr(w_addr),
    .i_imem_ack (w_req),
    .i_imem_data(w_addr | 32'h1000_0000),
    .o_pc4      (w_pc4),
    .o_order    (w_order),
    .o_flash    (w_flash)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset, then release on a falling edge: the following cycle is IDLE.
  task automatic do_reset();
    auto = 1'b0; ack_man = 1'b0; data_man = 32'd0;
    stall = 1'b0; redirect = 1'b0; target = 32'd0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (req !== 1'b0) begin $display("FAIL rst_req got=%0b exp=0", req); failures++; end
    checks++; if (flash !== 1'b1) begin $display("FAIL rst_flash got=%0b exp=1", flash); failures++; end
    checks++; if (order !== 32'd0) begin $display("FAIL rst_order got=%h exp=0", order); failures++; end
    checks++; if (pc4 !== 32'd4) begin $display("FAIL rst_pc4 got=%h exp=4", pc4); failures++; end
    checks++; if (addr !== 32'd0) begin $display("FAIL rst_addr got=%h exp=0", addr); failures++; end
  endtask

  task automatic test_zero_wait();
    logic [31:0] exp_addr [3] = '{32'd0, 32'd4, 32'd8};
    do_reset();
    #1;
    checks++; if (req !== 1'b0 || flash !== 1'b1) begin
      $display("FAIL zw_idle req=%0b flash=%0b exp req=0 flash=1", req, flash); failures++; end
    auto = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      checks++; if (req !== 1'b1 || addr !== exp_addr[i]) begin
        $display("FAIL zw_addr%0d req=%0b addr=%h exp req=1 addr=%h", i, req, addr, exp_addr[i]);
        failures++; end
      checks++; if (order !== (exp_addr[i] | 32'h1000_0000) || pc4 !== exp_addr[i] + 32'd4
                    || flash !== 1'b0) begin
        $display("FAIL zw_out%0d order=%h pc4=%h flash=%0b exp order=%h pc4=%h flash=0", i,
                 order, pc4, flash, exp_addr[i] | 32'h1000_0000, exp_addr[i] + 32'd4);
        failures++; end
    end
  endtask

  task automatic test_latency();
    do_reset();
    @(negedge clk); ack_man = 1'b1; data_man = 32'hA0; #1;
    checks++; if (addr !== 32'd0 || order !== 32'hA0 || flash !== 1'b0) begin
      $display("FAIL lat_first addr=%h order=%h flash=%0b exp 0/a0/0", addr, order, flash);
      failures++; end
    @(negedge clk); ack_man = 1'b0; #1;
    checks++; if (req !== 1'b1 || addr !== 32'd4 || flash !== 1'b1 || order !== 32'd0) begin
      $display("FAIL lat_wait req=%0b addr=%h flash=%0b order=%h exp 1/4/1/0", req, addr, flash,
               order); failures++; end
    @(negedge clk); ack_man = 1'b1; data_man = 32'hA4; #1;
    checks++; if (req !== 1'b1 || addr !== 32'd4 || flash !== 1'b0 || order !== 32'hA4
                  || pc4 !== 32'd8) begin
      $display("FAIL lat_ack addr=%h flash=%0b order=%h pc4=%h exp 4/0/a4/8", addr, flash, order,
               pc4); failures++; end
    @(negedge clk); ack_man = 1'b0; #1;
    checks++; if (addr !== 32'd8) begin
      $display("FAIL lat_next addr=%h exp=8", addr); failures++; end
  endtask

  task automatic test_stall();
    do_reset();
    @(negedge clk); ack_man = 1'b1; data_man = 32'h1; // addr 0
    @(negedge clk);                                   // addr 4
    @(negedge clk); data_man = 32'h2000_0001; stall = 1'b1; #1;
    checks++; if (addr !== 32'd8 || flash !== 1'b0) begin
      $display("FAIL st_ack addr=%h flash=%0b exp 8/0", addr, flash); failures++; end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); ack_man = 1'b0; data_man = 32'hBAD; #1;
      checks++; if (req !== 1'b0 || flash !== 1'b0) begin
        $display("FAIL st_hold%0d req=%0b flash=%0b exp 0/0", i, req, flash); failures++; end
    end
    @(negedge clk); stall = 1'b0; #1;
    checks++; if (order !== 32'h2000_0001 || pc4 !== 32'd12 || flash !== 1'b0) begin
      $display("FAIL st_release order=%h pc4=%h flash=%0b exp 20000001/c/0", order, pc4, flash);
      failures++; end
    @(negedge clk); #1;
    checks++; if (req !== 1'b1 || addr !== 32'd12) begin
      $display("FAIL st_next req=%0b addr=%h exp 1/c", req, addr); failures++; end
  endtask

  task automatic test_redirect();
    do_reset();
    auto = 1'b1;
    repeat (4) @(negedge clk); // fetch 0,4,8,c
    @(negedge clk); auto = 1'b0; ack_man = 1'b0; redirect = 1'b1; target = 32'h103; #1;
    checks++; if (addr !== 32'h10 || req !== 1'b1 || flash !== 1'b1 || order !== 32'd0) begin
      $display("FAIL rd_req addr=%h req=%0b flash=%0b order=%h exp 10/1/1/0", addr, req, flash,
               order); failures++; end
    @(negedge clk); redirect = 1'b0; #1;
    checks++; if (addr !== 32'h10 || req !== 1'b1 || flash !== 1'b1 || order !== 32'd0) begin
      $display("FAIL rd_drain addr=%h req=%0b flash=%0b order=%h exp 10/1/1/0", addr, req, flash,
               order); failures++; end
    @(negedge clk); ack_man = 1'b1; data_man = 32'hDEAD; #1;
    checks++; if (addr !== 32'h10 || flash !== 1'b1 || order !== 32'd0) begin
      $display("FAIL rd_discard addr=%h flash=%0b order=%h exp 10/1/0", addr, flash, order);
      failures++; end
    @(negedge clk); ack_man = 1'b1; data_man = 32'h55; stall = 1'b1; #1;
    checks++; if (addr !== 32'h100 || req !== 1'b1) begin
      $display("FAIL rd_target addr=%h req=%0b exp 100/1", addr, req); failures++; end
    @(negedge clk); ack_man = 1'b0; redirect = 1'b1; target = 32'h200; #1;
    checks++; if (req !== 1'b0 || flash !== 1'b1 || order !== 32'd0) begin
      $display("FAIL rd_hold req=%0b flash=%0b order=%h exp 0/1/0", req, flash, order);
      failures++; end
    @(negedge clk); redirect = 1'b0; stall = 1'b0; #1;
    checks++; if (addr !== 32'h200 || req !== 1'b1 || flash !== 1'b1) begin
      $display("FAIL rd_hold_tgt addr=%h req=%0b flash=%0b exp 200/1/1", addr, req, flash);
      failures++; end
    @(negedge clk); ack_man = 1'b1; data_man = 32'h77; #1;
    checks++; if (order !== 32'h77 || pc4 !== 32'h204 || flash !== 1'b0) begin
      $display("FAIL rd_after order=%h pc4=%h flash=%0b exp 77/204/0", order, pc4, flash);
      failures++; end
  endtask

  task automatic test_wrap();
    do_reset();
    #1;
    checks++; if (w_addr !== 32'hFFFF_FFFC || w_pc4 !== 32'd0 || w_req !== 1'b0) begin
      $display("FAIL wr_idle addr=%h pc4=%h req=%0b exp fffffffc/0/0", w_addr, w_pc4, w_req);
      failures++; end
    @(negedge clk); #1;
    checks++; if (w_addr !== 32'hFFFF_FFFC || w_pc4 !== 32'd0 || w_order !== 32'hFFFF_FFFC
                  || w_flash !== 1'b0) begin
      $display("FAIL wr_first addr=%h pc4=%h order=%h flash=%0b exp fffffffc/0/fffffffc/0",
               w_addr, w_pc4, w_order, w_flash); failures++; end
    @(negedge clk); #1;
    checks++; if (w_addr !== 32'd0 || w_pc4 !== 32'd4) begin
      $display("FAIL wr_second addr=%h pc4=%h exp 0/4", w_addr, w_pc4); failures++; end
  endtask

  task automatic test_reset_mid();
    // Reset while waiting on an unacked request at address 8.
    do_reset();
    auto = 1'b1;
    repeat (3) @(negedge clk); // fetch 0,4
    auto = 1'b0; ack_man = 1'b0;
    #1;
    checks++; if (req !== 1'b1 || addr !== 32'd8) begin
      $display("FAIL rm_setup req=%0b addr=%h exp 1/8", req, addr); failures++; end
    rst_n = 1'b0; #1;
    checks++; if (req !== 1'b0 || flash !== 1'b1 || addr !== 32'd0 || pc4 !== 32'd4) begin
      $display("FAIL rm_wait req=%0b flash=%0b addr=%h pc4=%h exp 0/1/0/4", req, flash, addr, pc4);
      failures++; end
    // Reset while holding a buffered instruction.
    do_reset();
    @(negedge clk); ack_man = 1'b1; data_man = 32'h11;
    @(negedge clk); data_man = 32'h22; stall = 1'b1;
    @(negedge clk); ack_man = 1'b0; #1;
    checks++; if (req !== 1'b0 || order !== 32'h22 || flash !== 1'b0) begin
      $display("FAIL rm_hold_setup req=%0b order=%h flash=%0b exp 0/22/0", req, order, flash);
      failures++; end
    rst_n = 1'b0; #1;
    checks++; if (req !== 1'b0 || flash !== 1'b1 || order !== 32'd0 || addr !== 32'd0) begin
      $display("FAIL rm_hold req=%0b flash=%0b order=%h addr=%h exp 0/1/0/0", req, flash, order,
               addr); failures++; end
  endtask

  initial begin
    checks = 0; failures = 0;
    auto = 1'b0; ack_man = 1'b0; data_man = 32'd0;
    stall = 1'b0; redirect = 1'b0; target = 32'd0;
    w_stall = 1'b0; w_redirect = 1'b0; w_target = 32'd0;
    rst_n = 1'b0;
    test_reset();
    test_zero_wait();
    test_latency();
    test_stall();
    test_redirect();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
